// File: rtl/vbs_video_gen.sv
// Composite-video (VBS) timing and 1bpp bitmap generator with CPU-writable video RAM.
// A fetch position runs one clock ahead of the displayed position so the synchronous RAM read lines up.
module vbs_video_gen #(
  parameter int H_TOTAL      = 512,
  parameter int V_TOTAL      = 313,
  parameter int H_SYNC_START = 2,
  parameter int H_SYNC_LEN   = 28,
  parameter int V_SYNC_LINES = 4,
  parameter int X_START      = 96,
  parameter int Y_START      = 35,
  parameter int W_BYTES      = 16,
  parameter int H_ROWS       = 128,
  parameter int Y_SCALE      = 2,
  parameter int ADDR_W       = $clog2(W_BYTES*H_ROWS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic                       invert,
  input  logic                       border,
  output logic                       sync,
  output logic                       pixel,
  output logic [$clog2(H_TOTAL)-1:0] hcount,
  output logic [$clog2(V_TOTAL)-1:0] vcount,
  output logic                       line_start,
  output logic                       frame_start,
  output logic                       vblank
);

  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int HX    = HW + 1;
  localparam int VX    = VW + 1;
  localparam int DEPTH = W_BYTES * H_ROWS;

  localparam logic [HX-1:0] H_LAST = HX'(H_TOTAL - 1);
  localparam logic [HX-1:0] HS_BEG = HX'(H_SYNC_START);
  localparam logic [HX-1:0] HS_END = HX'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [HX-1:0] HB_BEG = HX'(H_TOTAL - H_SYNC_LEN);
  localparam logic [HX-1:0] XW_BEG = HX'(X_START);
  localparam logic [HX-1:0] XW_END = HX'(X_START + 8*W_BYTES);
  localparam logic [VX-1:0] V_LAST = VX'(V_TOTAL - 1);
  localparam logic [VX-1:0] VS_END = VX'(V_SYNC_LINES);
  localparam logic [VX-1:0] YW_BEG = VX'(Y_START);
  localparam logic [VX-1:0] YW_END = VX'(Y_START + H_ROWS*Y_SCALE);

  localparam logic [HW-1:0]     X_BEG_H    = HW'(X_START);
  localparam logic [2:0]        X_PHASE    = 3'(X_START);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(W_BYTES);
  localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]        SUB_LAST   = 3'(Y_SCALE - 1);

  generate
    if (X_START + 8*W_BYTES > H_TOTAL) begin : g_bad_xwin
      $error("vbs_video_gen: window wider than line");
    end
    if (Y_START + H_ROWS*Y_SCALE > V_TOTAL) begin : g_bad_ywin
      $error("vbs_video_gen: window taller than frame");
    end
    if (H_SYNC_START + H_SYNC_LEN >= X_START) begin : g_bad_sync
      $error("vbs_video_gen: sync pulse overlaps window");
    end
    if (X_START < 2) begin : g_bad_xstart
      $error("vbs_video_gen: X_START must be at least 2");
    end
    if (Y_SCALE < 1 || Y_SCALE > 4) begin : g_bad_yscale
      $error("vbs_video_gen: Y_SCALE must be 1..4");
    end
  endgenerate

  function automatic logic sync_at(input logic [HW-1:0] h, input logic [VW-1:0] v);
    logic [HX-1:0] hx;
    logic [VX-1:0] vx;
    hx = {1'b0, h};
    vx = {1'b0, v};
    if (vx < VS_END) return hx >= HB_BEG;
    return !(hx >= HS_BEG && hx < HS_END);
  endfunction

  function automatic logic active_line(input logic [VW-1:0] v);
    logic [VX-1:0] vx;
    vx = {1'b0, v};
    return vx >= YW_BEG && vx < YW_END;
  endfunction

  function automatic logic in_window(input logic [HW-1:0] h, input logic [VW-1:0] v);
    logic [HX-1:0] hx;
    hx = {1'b0, h};
    return hx >= XW_BEG && hx < XW_END && active_line(v);
  endfunction

  logic [7:0] ram_q [DEPTH];

  logic [HW-1:0]     fh_q, fh_d;
  logic [VW-1:0]     fv_q, fv_d;
  logic [ADDR_W-1:0] frow_q, frow_d;
  logic [2:0]        fsub_q, fsub_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [HW-1:0]     nh_q, nh_d;
  logic [VW-1:0]     nv_q, nv_d;

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic sync_q, sync_d, pixel_q, pixel_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d, vblank_q, vblank_d;

  logic              fwin;
  logic [HW-1:0]     fcol;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        k3;

  // RAM is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_X)) ram_q[wr_addr] <= wr_data;
  end

  // Fetch side: position one clock ahead of what is displayed, plus bitmap row tracking.
  always_comb begin
    fh_d   = fh_q + 1'b1;
    fv_d   = fv_q;
    frow_d = frow_q;
    fsub_d = fsub_q;
    if ({1'b0, fh_q} == H_LAST) begin
      fh_d = '0;
      fv_d = ({1'b0, fv_q} == V_LAST) ? '0 : fv_q + 1'b1;
      if ({1'b0, fv_d} == YW_BEG) begin
        frow_d = '0;
        fsub_d = '0;
      end else if (fsub_q == SUB_LAST) begin
        fsub_d = '0;
        frow_d = frow_q + 1'b1;
      end else begin
        fsub_d = fsub_q + 3'd1;
      end
    end
    fwin    = in_window(fh_q, fv_q);
    fcol    = (fh_q - X_BEG_H) >> 3;
    rd_addr = frow_q * ROW_STRIDE + ADDR_W'(fcol);
    rdata_d = fwin ? ram_q[rd_addr] : '0;
    nh_d    = fh_q;
    nv_d    = fv_q;
  end

  // Display side: everything registered for the position held in nh/nv.
  always_comb begin
    hcount_d      = nh_q;
    vcount_d      = nv_q;
    sync_d        = sync_at(nh_q, nv_q);
    k3            = nh_q[2:0] - X_PHASE;
    pixel_d       = in_window(nh_q, nv_q) ? (rdata_q[3'd7 - k3] ^ invert) : (sync_d & border);
    line_start_d  = (nh_q == '0);
    frame_start_d = (nh_q == '0) && (nv_q == '0);
    vblank_d      = !active_line(nv_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fh_q          <= HW'(1);
      fv_q          <= '0;
      frow_q        <= '0;
      fsub_q        <= '0;
      rdata_q       <= '0;
      nh_q          <= '0;
      nv_q          <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      sync_q        <= 1'b1;
      pixel_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b1;
    end else begin
      fh_q          <= fh_d;
      fv_q          <= fv_d;
      frow_q        <= frow_d;
      fsub_q        <= fsub_d;
      rdata_q       <= rdata_d;
      nh_q          <= nh_d;
      nv_q          <= nv_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      sync_q        <= sync_d;
      pixel_q       <= pixel_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign sync        = sync_q;
  assign pixel       = pixel_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vblank      = vblank_q;

endmodule

// File: tb/tb_vbs_video_gen.sv
// Scoreboard bench for vbs_video_gen, using a reduced timing set so whole frames stay short.
module tb_vbs_video_gen;

  localparam int HT  = 64;
  localparam int VT  = 40;
  localparam int HS0 = 2;
  localparam int HSL = 6;
  localparam int VSL = 2;
  localparam int X0  = 16;
  localparam int Y0  = 6;
  localparam int WB  = 4;
  localparam int HR  = 8;
  localparam int YS  = 3;
  localparam int NB  = WB * HR;
  localparam int AW  = $clog2(NB);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic invert = 1'b0;
  logic border = 1'b0;
  logic sync, pixel, line_start, frame_start, vblank;
  logic [$clog2(HT)-1:0] hcount;
  logic [$clog2(VT)-1:0] vcount;

  vbs_video_gen #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_START(HS0), .H_SYNC_LEN(HSL),
    .V_SYNC_LINES(VSL), .X_START(X0), .Y_START(Y0), .W_BYTES(WB),
    .H_ROWS(HR), .Y_SCALE(YS)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .invert(invert), .border(border), .sync(sync), .pixel(pixel),
    .hcount(hcount), .vcount(vcount), .line_start(line_start),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] mem_m [NB];

  function automatic int m_sync(input int h, input int v);
    if (v < VSL) return (h >= HT - HSL) ? 1 : 0;
    return (h >= HS0 && h < HS0 + HSL) ? 0 : 1;
  endfunction

  function automatic int m_vblank(input int v);
    return (v >= Y0 && v < Y0 + HR*YS) ? 0 : 1;
  endfunction

  function automatic int m_pixel(input int h, input int v);
    int r, k;
    logic [7:0] b;
    if (h >= X0 && h < X0 + 8*WB && m_vblank(v) == 0) begin
      r = (v - Y0) / YS;
      k = h - X0;
      b = mem_m[r*WB + k/8];
      return int'(b[7 - k%8] ^ invert);
    end
    return (m_sync(h, v) == 1) ? int'(border) : 0;
  endfunction

  typedef struct {
    int h;
    int v;
    int sel;
    int exp;
  } exp_t;
  exp_t sb[$];

  task automatic expect_at(input int v, input int h, input int sel);
    exp_t e;
    e.h = h;
    e.v = v;
    e.sel = sel;
    case (sel)
      0:       e.exp = m_sync(h, v);
      1:       e.exp = m_pixel(h, v);
      default: e.exp = m_vblank(v);
    endcase
    sb.push_back(e);
  endtask

  exp_t cur;
  int obs_v;
  string sel_name;
  int frames_seen = 0;
  int last_fs = 0, last_ls = 0;
  bit have_fs = 1'b0, have_ls = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && int'(hcount) == sb[0].h && int'(vcount) == sb[0].v) begin
        cur = sb.pop_front();
        case (cur.sel)
          0:       begin obs_v = int'(sync);   sel_name = "sync";   end
          1:       begin obs_v = int'(pixel);  sel_name = "pixel";  end
          default: begin obs_v = int'(vblank); sel_name = "vblank"; end
        endcase
        chk($sformatf("%s@v%0d,h%0d", sel_name, cur.v, cur.h), obs_v, cur.exp);
      end
      if (frame_start) begin
        if (have_fs) begin
          chk("frame_period", cyc - last_fs, HT*VT);
          frames_seen++;
        end
        have_fs = 1'b1;
        last_fs = cyc;
      end
      if (line_start) begin
        if (have_ls) chk("line_period", cyc - last_ls, HT);
        have_ls = 1'b1;
        last_ls = cyc;
      end
    end
  end

  task automatic write_byte(input int a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    mem_m[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pos(input int h, input int v, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(hcount) == h && int'(vcount) == v) return;
      @(negedge clk);
    end
    chk("wait_pos_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    chk("scoreboard_left", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    repeat (3) @(negedge clk);
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_vcount", int'(vcount), 0);
    chk("rst_sync", int'(sync), 1);
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_line_start", int'(line_start), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_vblank", int'(vblank), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_hcount", int'(hcount), 0);
    chk("rel_vcount", int'(vcount), 0);
    chk("rel_line_start", int'(line_start), 1);
    chk("rel_frame_start", int'(frame_start), 1);

    for (int i = 0; i < NB; i++)
      write_byte(i, (i == 0) ? 8'h80 : (i == NB-1) ? 8'h01 : 8'h00);

    // Mid-line reset; RAM must keep its contents.
    wait_pos(40, 0, 200);
    reset = 1'b1;
    have_fs = 1'b0;
    have_ls = 1'b0;
    #1;
    chk("mid_hcount", int'(hcount), 0);
    chk("mid_vcount", int'(vcount), 0);
    chk("mid_sync", int'(sync), 1);
    chk("mid_pixel", int'(pixel), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    expect_at(0, 57, 0); expect_at(0, 58, 0); expect_at(0, 63, 0);
    expect_at(1, 10, 0);
    expect_at(3, 1, 0);  expect_at(3, 2, 0);  expect_at(3, 7, 0);  expect_at(3, 8, 0);
    expect_at(5, 20, 2);
    expect_at(6, 15, 1); expect_at(6, 16, 1); expect_at(6, 16, 2); expect_at(6, 17, 1);
    expect_at(7, 16, 1); expect_at(8, 16, 1); expect_at(9, 16, 1);
    expect_at(27, 46, 1); expect_at(27, 47, 1); expect_at(28, 47, 1);
    expect_at(29, 47, 1); expect_at(29, 47, 2);
    expect_at(30, 47, 1); expect_at(30, 47, 2);
    drain(HT*VT + 200);

    invert = 1'b1;
    border = 1'b1;
    for (int i = 0; i < NB; i++) write_byte(i, 8'h00);
    expect_at(0, 10, 1); expect_at(0, 60, 1);
    expect_at(3, 4, 1);  expect_at(3, 10, 1);
    expect_at(6, 16, 1); expect_at(20, 30, 1); expect_at(29, 47, 1);
    expect_at(35, 50, 1);
    drain(2*HT*VT + 200);

    f0 = frames_seen;
    for (int i = 0; i < 3*HT*VT && frames_seen < f0 + 2; i++) @(negedge clk);
    chk("frames_observed", (frames_seen >= f0 + 2) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
